// File: rtl/enc8b10b_lanes_if.sv
// -----------------------------------------------------------------------------
// enc8b10b_lanes_if
// Beat-level handshake bundle between the framing logic (master) and the
// multi-lane 8b/10b encoder (slave).
//   in_valid  : input beat valid                  (master -> slave)
//   in_ready  : encoder can accept an input beat  (slave  -> master)
//   in_data   : LANES bytes, lane n = [8n+7:8n], HGFEDCBA
//   in_k      : per-lane control-character flag
//   out_valid : encoded beat valid                (slave  -> master)
//   out_ready : downstream accepts encoded beat   (master -> slave)
//   out_data  : LANES codewords, lane n = [10n+9:10n] = {a,b,c,d,e,i,f,g,h,j}
//   out_kerr  : per-lane illegal K request flag
// -----------------------------------------------------------------------------
interface enc8b10b_lanes_if #(
   parameter int LANES = 2
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [8*LANES-1:0]    in_data;
   logic [LANES-1:0]      in_k;
   logic                  out_valid;
   logic                  out_ready;
   logic [10*LANES-1:0]   out_data;
   logic [LANES-1:0]      out_kerr;

   modport master (
      output in_valid, in_data, in_k, out_ready,
      input  in_ready, out_valid, out_data, out_kerr
   );

   modport slave (
      input  in_valid, in_data, in_k, out_ready,
      output in_ready, out_valid, out_data, out_kerr
   );
endinterface

// File: rtl/enc8b10b_lanes.sv
// -----------------------------------------------------------------------------
// enc8b10b_lanes
// Multi-lane 8b/10b encoder with running-disparity chaining across lanes and
// beats, K-code support and a two-stage valid/ready pipeline (S1 input
// register, S2 encoded output register).
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, empties both stages, RD -> neg
//   rd_clear : synchronous force of RD to negative
//   bus      : enc8b10b_lanes_if.slave handshake/data bundle
//   rd_out   : current running-disparity register (0 = negative)
// Build option:
//   ENC_KCHECK_EN : when defined, illegal K requests raise out_kerr for that
//                   lane and are replaced by K.28.5; otherwise out_kerr is 0
//                   and the raw bits are pushed through the K rules.
// -----------------------------------------------------------------------------
module enc8b10b_lanes #(
   parameter int LANES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_clear,
   enc8b10b_lanes_if.slave  bus,
   output logic             rd_out
);

   // 5b/6b code (abcdei) in its RD-negative form
   function automatic logic [5:0] code6_neg(input logic [4:0] x, input logic k);
      logic [5:0] c;
      if (k && (x == 5'd28)) begin
         c = 6'b001111;
      end else begin
         case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
         endcase
      end
      return c;
   endfunction

   // 3b/4b data code (fghj) in its RD-negative form, primary D.x.7
   function automatic logic [3:0] code4d_neg(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0:    c = 4'b1011;
         3'd1:    c = 4'b1001;
         3'd2:    c = 4'b0101;
         3'd3:    c = 4'b1100;
         3'd4:    c = 4'b1101;
         3'd5:    c = 4'b1010;
         3'd6:    c = 4'b0110;
         default: c = 4'b1110;
      endcase
      return c;
   endfunction

   // 3b/4b control code in its RD-negative form; y=7 doubles as D.x.A7
   function automatic logic [3:0] code4k_neg(input logic [2:0] y);
      logic [3:0] c;
      case (y)
         3'd0:    c = 4'b1011;
         3'd1:    c = 4'b0110;
         3'd2:    c = 4'b1010;
         3'd3:    c = 4'b1100;
         3'd4:    c = 4'b1101;
         3'd5:    c = 4'b0101;
         3'd6:    c = 4'b1001;
         default: c = 4'b0111;
      endcase
      return c;
   endfunction

   function automatic logic balanced6(input logic [5:0] c);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 6; i++) n = n + {2'b00, c[i]};
      return (n == 3'd3);
   endfunction

   function automatic logic balanced4(input logic [3:0] c);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) n = n + {2'b00, c[i]};
      return (n == 3'd2);
   endfunction

   // Encode one byte: returns {rd_after, abcdei_fghj}. The RD-positive form
   // is the complement of the RD-negative form for every unbalanced code,
   // for the D.7 / D.x.3 neutral pairs and for all K 4b codes. RD flips
   // whenever the emitted sub-block is unbalanced.
   function automatic logic [10:0] enc_lane(input logic [7:0] d, input logic k,
                                            input logic rd_in);
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] c6;
      logic [3:0] c4;
      logic       bal6;
      logic       bal4;
      logic       rd_mid;
      logic       use_alt;
      x      = d[4:0];
      y      = d[7:5];
      c6     = code6_neg(x, k);
      bal6   = balanced6(c6);
      if (rd_in && (!bal6 || (x == 5'd7))) c6 = ~c6;
      else                                  c6 = c6;
      rd_mid = bal6 ? rd_in : ~rd_in;
      // D.x.A7 avoids a run of five equal bits across the e/i-f boundary
      use_alt = !k && (y == 3'd7) &&
                ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                 ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
      if (k || use_alt) c4 = code4k_neg(y);
      else              c4 = code4d_neg(y);
      bal4 = balanced4(c4);
      if (rd_mid && (k || !bal4 || (y == 3'd3))) c4 = ~c4;
      else                                        c4 = c4;
      return {(bal4 ? rd_mid : ~rd_mid), c6, c4};
   endfunction

`ifdef ENC_KCHECK_EN
   function automatic logic k_legal(input logic [7:0] d);
      logic ok;
      case (d)
         8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
         8'hF7, 8'hFB, 8'hFD, 8'hFE: ok = 1'b1;
         default:                    ok = 1'b0;
      endcase
      return ok;
   endfunction
`endif

   logic                  s1_valid_r;
   logic [8*LANES-1:0]    s1_data_r;
   logic [LANES-1:0]      s1_k_r;
   logic                  s2_valid_r;
   logic [10*LANES-1:0]   out_data_r;
   logic                  rd_r;
   logic                  s1_adv_s;
   logic                  in_fire_s;
   logic [10*LANES-1:0]   enc_data_s;
   logic                  rd_end_s;
`ifdef ENC_KCHECK_EN
   logic [LANES-1:0]      out_kerr_r;
   logic [LANES-1:0]      enc_kerr_s;
`endif

   assign s1_adv_s      = s1_valid_r & (~s2_valid_r | bus.out_ready);
   assign bus.in_ready  = ~s1_valid_r | s1_adv_s;
   assign in_fire_s     = bus.in_valid & bus.in_ready;
   assign bus.out_valid = s2_valid_r;
   assign bus.out_data  = out_data_r;
   assign rd_out        = rd_r;
`ifdef ENC_KCHECK_EN
   assign bus.out_kerr  = out_kerr_r;
`else
   assign bus.out_kerr  = '0;
`endif

   // Lane-by-lane encode of the S1 beat, RD rippling lane 0 -> LANES-1;
   // a concurrent rd_clear restarts the chain from negative
   always_comb begin : enc_chain
      logic       rd_v;
      logic [7:0] byte_v;
      logic       k_v;
      logic [10:0] res_v;
      rd_v       = rd_clear ? 1'b0 : rd_r;
      byte_v     = 8'h00;
      k_v        = 1'b0;
      res_v      = 11'd0;
      enc_data_s = '0;
`ifdef ENC_KCHECK_EN
      enc_kerr_s = '0;
`endif
      for (int n = 0; n < LANES; n++) begin
         byte_v = s1_data_r[8*n +: 8];
         k_v    = s1_k_r[n];
`ifdef ENC_KCHECK_EN
         if (k_v && !k_legal(byte_v)) begin
            enc_kerr_s[n] = 1'b1;
            byte_v        = 8'hBC;
         end else begin
            enc_kerr_s[n] = 1'b0;
         end
`endif
         res_v                   = enc_lane(byte_v, k_v, rd_v);
         enc_data_s[10*n +: 10]  = res_v[9:0];
         rd_v                    = res_v[10];
      end
      rd_end_s = rd_v;
   end

   // S1 input register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= '0;
         s1_k_r     <= '0;
      end else if (in_fire_s) begin
         s1_valid_r <= 1'b1;
         s1_data_r  <= bus.in_data;
         s1_k_r     <= bus.in_k;
      end else if (s1_adv_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // S2 output register; holds its contents while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         out_data_r <= '0;
      end else if (s1_adv_s) begin
         s2_valid_r <= 1'b1;
         out_data_r <= enc_data_s;
      end else if (bus.out_ready) begin
         s2_valid_r <= 1'b0;
      end else begin
         s2_valid_r <= s2_valid_r;
      end
   end

`ifdef ENC_KCHECK_EN
   // Per-lane illegal-K flags travel with the S2 beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_kerr_r <= '0;
      end else if (s1_adv_s) begin
         out_kerr_r <= enc_kerr_s;
      end else begin
         out_kerr_r <= out_kerr_r;
      end
   end
`endif

   // Running disparity: beat result on advance, otherwise rd_clear forces negative
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_r <= 1'b0;
      end else if (s1_adv_s) begin
         rd_r <= rd_end_s;
      end else if (rd_clear) begin
         rd_r <= 1'b0;
      end else begin
         rd_r <= rd_r;
      end
   end

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// -----------------------------------------------------------------------------
// tb_enc8b10b_lanes
// Directed vectors with hand-computed codewords for a 2-lane encoder. The
// stimulus side pushes each beat's expected codewords / kerr / RD into a
// queue; a monitor pops and compares whenever the encoder presents a beat.
// -----------------------------------------------------------------------------
module tb_enc8b10b_lanes;
   localparam int LANES = 2;

   typedef struct packed {
      logic [19:0] data;
      logic [1:0]  kerr;
      logic        rd;
   } exp_t;

   logic clk;
   logic rst_n;
   logic rd_clear;
   logic rd_out;
   int   checks = 0;
   int   errs   = 0;
   exp_t exp_q[$];

   enc8b10b_lanes_if #(.LANES(LANES)) bus ();

   enc8b10b_lanes #(.LANES(LANES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_clear (rd_clear),
      .bus      (bus),
      .rd_out   (rd_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: compare the presented beat with the queue head; pop on handshake
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_beat: got data %h, expected no beat", bus.out_data);
         end else begin
            chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
            chk("out_kerr", 32'(bus.out_kerr), 32'(exp_q[0].kerr));
            if (bus.out_ready) begin
               chk("rd_out", 32'(rd_out), 32'(exp_q[0].rd));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [15:0] d, input logic [1:0] k, input logic clr,
                       input logic [19:0] ed, input logic [1:0] ek, input logic er);
      exp_t e;
      int   w;
      e.data = ed;
      e.kerr = ek;
      e.rd   = er;
      exp_q.push_back(e);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_k     = k;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 20) begin
         w++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         errs++;
         $display("FAIL accept_timeout: in_ready %b, expected 1", bus.in_ready);
         bus.in_valid = 1'b0;
         void'(exp_q.pop_back());
      end else begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         if (clr) begin
            rd_clear = 1'b1;
            @(posedge clk);
            #1;
            rd_clear = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      rd_clear     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_k     = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_kerr",  32'(bus.out_kerr),  32'd0);
      chk("rst_rd_out",    32'(rd_out),        32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // data / K vectors, RD chained lane0 -> lane1 -> next beat
      send({8'h00, 8'h00}, 2'b00, 1'b0, {10'h274, 10'h274}, 2'b00, 1'b0);
      send({8'h00, 8'h00}, 2'b00, 1'b1, {10'h274, 10'h274}, 2'b00, 1'b0);
      send({8'hBC, 8'hBC}, 2'b11, 1'b0, {10'h305, 10'h0FA}, 2'b00, 1'b0);
      send({8'hB5, 8'hBC}, 2'b01, 1'b0, {10'h2AA, 10'h0FA}, 2'b00, 1'b1);
      send({8'h00, 8'h00}, 2'b00, 1'b0, {10'h18B, 10'h18B}, 2'b00, 1'b1);
      // rd_clear while this beat advances: encoded from RD negative
      send({8'h00, 8'h00}, 2'b00, 1'b1, {10'h274, 10'h274}, 2'b00, 1'b0);
      // D.17.7 alternate at RD-, D.11.7 alternate at RD+
      send({8'hEB, 8'hF1}, 2'b00, 1'b0, {10'h348, 10'h237}, 2'b00, 1'b0);
      // D.0.7 primary, D.7.3 at RD-
      send({8'h67, 8'hE0}, 2'b00, 1'b0, {10'h38C, 10'h271}, 2'b00, 1'b0);
      // K.28.5 then D.7.3 at RD+
      send({8'h67, 8'hBC}, 2'b01, 1'b0, {10'h073, 10'h0FA}, 2'b00, 1'b1);
      // K.23.7 at RD+, K.28.1 at RD+
      send({8'h3C, 8'hF7}, 2'b11, 1'b0, {10'h306, 10'h057}, 2'b00, 1'b0);
      // illegal K on lane 0
`ifdef ENC_KCHECK_EN
      send({8'h00, 8'h00}, 2'b01, 1'b0, {10'h18B, 10'h0FA}, 2'b01, 1'b1);
`else
      send({8'h00, 8'h00}, 2'b01, 1'b0, {10'h274, 10'h274}, 2'b00, 1'b0);
`endif
      drain();

      // idle rd_clear
      @(posedge clk);
      #1;
      rd_clear = 1'b1;
      @(posedge clk);
      #1;
      rd_clear = 1'b0;
      @(negedge clk);
      chk("rd_clear_idle", 32'(rd_out), 32'd0);

      // stall: two beats fill both stages, hold 3 cycles, then release
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      send({8'h00, 8'h00}, 2'b00, 1'b0, {10'h274, 10'h274}, 2'b00, 1'b0);
      send({8'hB5, 8'hBC}, 2'b01, 1'b0, {10'h2AA, 10'h0FA}, 2'b00, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
         chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send({8'h00, 8'h00}, 2'b00, 1'b0, {10'h18B, 10'h18B}, 2'b00, 1'b1);
      drain();

      // reset with both stages full and RD positive
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      send({8'h00, 8'h00}, 2'b00, 1'b0, {10'h18B, 10'h18B}, 2'b00, 1'b1);
      send({8'h00, 8'h00}, 2'b00, 1'b0, {10'h18B, 10'h18B}, 2'b00, 1'b1);
      @(negedge clk);
      chk("pre_reset_rd",       32'(rd_out),       32'd1);
      chk("pre_reset_in_ready", 32'(bus.in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_reset_rd_out",    32'(rd_out),        32'd0);
      chk("mid_reset_in_ready",  32'(bus.in_ready),  32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      send({8'h00, 8'h00}, 2'b00, 1'b0, {10'h274, 10'h274}, 2'b00, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule

// File: doc/enc8b10b_lanes.md
# enc8b10b_lanes

Parametrised multi-lane 8b/10b encoder: the complete successor to the 3b/4b transform stage, with the 5b/6b and 3b/4b sub-blocks, running-disparity (RD) tracking, K-code handling and a two-stage valid/ready pipeline. It encodes LANES bytes per beat. RD is chained lane 0 → LANES-1 within a beat and carried across beats. It sits between the framing logic and the serializer.

## Interface
- LANES, 2, number of bytes encoded per beat (1..8)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input beat
- in_data  in  8*LANES  lane n = bits [8n+7:8n], bit order HGFEDCBA (H = MSB)
- in_k  in  LANES  lane n is a control character
- rd_clear  in  1  synchronous force of RD to negative
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output beat
- out_data  out  10*LANES  lane n = bits [10n+9:10n] = {a,b,c,d,e,i,f,g,h,j}, a = MSB, transmitted first
- out_kerr  out  LANES  lane n carried an illegal K request (see Configuration)
- rd_out  out  1  current RD register (0 = negative, 1 = positive)

## Operation
- Stage S1 is the input register. On in_valid & in_ready it captures in_data and in_k.
- Stage S2 is the encode/output register. Encoding is combinational from S1 plus the RD register, and is captured into S2 when S1 advances.
- S1 advances when S1 is valid and (S2 is empty or out_ready).
- in_ready = ~S1_valid | S1_advance. A combinational path from out_ready to in_ready is permitted.
- RD chain:
  - lane 0 encodes with the RD register value;
  - lane n+1 encodes with the RD after lane n;
  - after lane LANES-1, the result is written to the RD register on S1 advance only.
- Per lane, the 5b/6b code is selected by RD-in.
- The 3b/4b code is selected by the RD after the 6b sub-block.
- Sub-block RD rule: a nonzero-disparity sub-block flips RD; a zero-disparity sub-block leaves it.
  - Exception: D.x.3/000111 and 111000 variants use their RD-specific form without flipping.
- D.x.7 uses the alternate 0111/1000 form when:
  - RD is negative and x ∈ {17,18,20}, or
  - RD is positive and x ∈ {11,13,14}.
- K.28.y, K.23.7, K.27.7, K.29.7, K.30.7 use the standard control encodings.
- rd_clear:
  - forces the RD register negative at the next edge;
  - if S1 advances in the same cycle, that beat is encoded starting from RD negative, and its resulting RD is written instead.
- S2 holds out_data/out_kerr stable while out_valid & ~out_ready.

## Timing
- Reset values: in_ready = 1 (combinational from empty S1), out_valid = 0, out_data = 0, out_kerr = 0, rd_out = 0, S1/S2 empty.
- Latency: a beat accepted at edge N is presented on out_data with out_valid = 1 after edge N+1.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: with out_ready = 0 and both stages full, in_ready = 0 and no state changes except the rd_clear effect on the RD register.
- Reset mid-operation discards both stages immediately and returns RD to negative. Beats in flight are lost, not flushed.
- Every lane of one beat always advances together; lanes are never split across beats.

## Configuration
- ENC_KCHECK_EN defined:
  - in_k = 1 with a byte not in {1C,3C,5C,7C,9C,BC,DC,FC,F7,FB,FD,FE} sets out_kerr[n] = 1 on that beat;
  - that lane's codeword is replaced by K.28.5 for its RD-in, and RD is updated accordingly.
- ENC_KCHECK_EN undefined:
  - out_kerr is tied to 0;
  - an illegal K is encoded by applying the K rules to the raw bits. The result is unspecified but deterministic, and RD still follows the emitted codeword's disparity.

## Test plan
- Reset, LANES=1, RD−, D.0.0 (8'h00, k=0) → out_data = 10'h274, rd_out stays 0. Next beat D.0.0 with rd_clear pulsed → 10'h274 again.
- LANES=2, RD−, both lanes K.28.5 (8'hBC, k=1) → lane0 10'h0FA, lane1 10'h305, rd_out = 0 afterwards.
- RD forced positive by one K.28.5, then D.21.5 (8'hB5) → 10'h2AA, rd_out unchanged at 1. Then D.0.0 → 10'h18B, rd_out = 1.
- Back-to-back beats with out_ready held 0 for 3 cycles:
  - in_ready drops after 2 beats accepted;
  - out_data is stable throughout the stall;
  - all beats emerge in order with the correct RD chain once out_ready = 1.
- ENC_KCHECK_EN: lane 0 k=1, 8'h00, RD− → out_kerr[0] = 1, out_data lane0 = 10'h0FA, rd_out = 1.
- rst_n asserted while both stages are full → out_valid = 0 and rd_out = 0 immediately. The first post-reset beat D.0.0 → 10'h274.
